// File: rtl/bram_pl_loader_if.sv
// Bus bundle between the preload initiator and its neighbours: the incoming
// write-word stream, the outgoing readback stream and the BRAM PL port.
interface bram_pl_loader_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 36
);
  // write-word stream from the boot controller
  logic              wdata_valid_i;
  logic [DATA_W-1:0] wdata_i;
  logic              wdata_ready_o;
  // readback stream towards the boot controller
  logic              rdata_valid_o;
  logic [DATA_W-1:0] rdata_o;
  logic              rdata_ready_i;
  // PL port of the BRAM tile
  logic              PL_INIT_o;
  logic              PL_ENA_o;
  logic              PL_REN_o;
  logic [1:0]        PL_WEN_o;
  logic [ADDR_W-1:0] PL_ADDR_o;
  logic [DATA_W-1:0] PL_DATA_o;
  logic [DATA_W-1:0] PL_DATA_i;

  // loader side
  modport master (
    input  wdata_valid_i, wdata_i, rdata_ready_i, PL_DATA_i,
    output wdata_ready_o, rdata_valid_o, rdata_o,
    output PL_INIT_o, PL_ENA_o, PL_REN_o, PL_WEN_o, PL_ADDR_o, PL_DATA_o
  );

  // stream source/sink and BRAM side
  modport slave (
    output wdata_valid_i, wdata_i, rdata_ready_i, PL_DATA_i,
    input  wdata_ready_o, rdata_valid_o, rdata_o,
    input  PL_INIT_o, PL_ENA_o, PL_REN_o, PL_WEN_o, PL_ADDR_o, PL_DATA_o
  );
endinterface

// File: rtl/bram_pl_loader.sv
// Preload initiator for the BRAM PL port. A write session streams words into
// consecutive BRAM addresses; a readback session issues one PL read at a time
// and hands each captured word out on the readback stream. Every output is a
// register, so the FSM decodes its outputs from the next state.
module bram_pl_loader #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 36,
  parameter int CNT_W  = 16,
  parameter int RD_LAT = 1
) (
  input  logic              PL_CLK_i,
  input  logic              global_resetn,
  input  logic              start_i,
  input  logic              mode_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic [CNT_W-1:0]  word_count_i,
  input  logic              abort_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  bram_pl_loader_if.master  bus
);

  typedef enum logic [2:0] {
    IDLE, SETUP, WRITE, RD_ISSUE, RD_WAIT, RD_HOLD, DONE
  } state_t;

  // last RD_WAIT cycle index; RD_LAT is limited to 1..4
  localparam logic [1:0] LAT_LAST = 2'(RD_LAT - 1);

  state_t            state, state_n;
  logic              mode_q;
  logic [ADDR_W-1:0] addr_q, addr_n;
  logic [CNT_W-1:0]  rem_q, rem_n;
  logic [1:0]        wcnt_q, wcnt_n;
  logic              wr_fire;
  logic              rd_capture;
  logic              accept_start;
  logic              do_abort;

  assign accept_start = (state == IDLE) && start_i;
  assign do_abort     = (state != IDLE) && abort_i;

  // next state, address/count bookkeeping; abort overrides everything
  always_comb begin
    state_n    = state;
    addr_n     = addr_q;
    rem_n      = rem_q;
    wcnt_n     = wcnt_q;
    wr_fire    = 1'b0;
    rd_capture = 1'b0;
    case (state)
      IDLE: begin
        if (start_i) begin
          state_n = SETUP;
          addr_n  = base_addr_i;
          rem_n   = word_count_i;
        end
      end
      SETUP: begin
        if (rem_q == '0)  state_n = DONE;
        else if (mode_q)  state_n = RD_ISSUE;
        else              state_n = WRITE;
      end
      WRITE: begin
        if (bus.wdata_valid_i && bus.wdata_ready_o) begin
          wr_fire = 1'b1;
          addr_n  = addr_q + ADDR_W'(1);
          rem_n   = rem_q - CNT_W'(1);
          if (rem_q == CNT_W'(1)) state_n = DONE;
        end
      end
      RD_ISSUE: begin
        state_n = RD_WAIT;
        wcnt_n  = '0;
      end
      RD_WAIT: begin
        if (wcnt_q == LAT_LAST) begin
          state_n    = RD_HOLD;
          rd_capture = 1'b1;
        end else begin
          wcnt_n = wcnt_q + 2'd1;
        end
      end
      RD_HOLD: begin
        // rdata_valid_o is always high here, so ready alone completes the handshake
        if (bus.rdata_ready_i) begin
          addr_n  = addr_q + ADDR_W'(1);
          rem_n   = rem_q - CNT_W'(1);
          state_n = (rem_q == CNT_W'(1)) ? DONE : RD_ISSUE;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (do_abort) begin
      state_n    = DONE;
      addr_n     = addr_q;
      rem_n      = rem_q;
      wr_fire    = 1'b0;
      rd_capture = 1'b0;
    end
  end

  // state and session bookkeeping registers
  always_ff @(posedge PL_CLK_i or negedge global_resetn) begin
    if (!global_resetn) begin
      state  <= IDLE;
      mode_q <= 1'b0;
      addr_q <= '0;
      rem_q  <= '0;
      wcnt_q <= '0;
    end else begin
      state  <= state_n;
      addr_q <= addr_n;
      rem_q  <= rem_n;
      wcnt_q <= wcnt_n;
      if (accept_start) mode_q <= mode_i;
    end
  end

  // registered outputs: status and strobes decoded from the next state
  always_ff @(posedge PL_CLK_i or negedge global_resetn) begin
    if (!global_resetn) begin
      busy_o            <= 1'b0;
      done_o            <= 1'b0;
      err_o             <= 1'b0;
      bus.wdata_ready_o <= 1'b0;
      bus.rdata_valid_o <= 1'b0;
      bus.rdata_o       <= '0;
      bus.PL_INIT_o     <= 1'b0;
      bus.PL_ENA_o      <= 1'b0;
      bus.PL_REN_o      <= 1'b0;
      bus.PL_WEN_o      <= 2'b00;
      bus.PL_ADDR_o     <= '0;
      bus.PL_DATA_o     <= '0;
    end else begin
      busy_o            <= (state_n != IDLE);
      done_o            <= (state_n == DONE);
      bus.PL_INIT_o     <= (state_n != IDLE);
      bus.wdata_ready_o <= (state_n == WRITE);
      bus.rdata_valid_o <= (state_n == RD_HOLD);
      bus.PL_ENA_o      <= wr_fire || (state_n == RD_ISSUE);
      bus.PL_REN_o      <= (state_n == RD_ISSUE);
      bus.PL_WEN_o      <= wr_fire ? 2'b11 : 2'b00;
      // address/data hold their last value between accesses
      if (wr_fire) begin
        bus.PL_ADDR_o <= addr_q;
        bus.PL_DATA_o <= bus.wdata_i;
      end else if (state_n == RD_ISSUE) begin
        bus.PL_ADDR_o <= addr_n;
      end
      if (rd_capture) bus.rdata_o <= bus.PL_DATA_i;
      if (accept_start)  err_o <= 1'b0;
      else if (do_abort) err_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_bram_pl_loader.sv
// Scoreboard bench for bram_pl_loader: expected PL accesses and readback words
// are queued as stimulus is driven, and compared against what a PL-port
// recorder and the readback stream actually show.
module tb_bram_pl_loader;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 36;
  localparam int CNT_W  = 16;
  localparam int LAT    = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start_i = 1'b0;
  logic              mode_i = 1'b0;
  logic              abort_i = 1'b0;
  logic [ADDR_W-1:0] base_addr_i = '0;
  logic [CNT_W-1:0]  word_count_i = '0;
  logic              busy_o, done_o, err_o;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int stray = 0;

  bram_pl_loader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  bram_pl_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W), .RD_LAT(LAT)) dut (
    .PL_CLK_i     (clk),
    .global_resetn(rst_n),
    .start_i      (start_i),
    .mode_i       (mode_i),
    .base_addr_i  (base_addr_i),
    .word_count_i (word_count_i),
    .abort_i      (abort_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .err_o        (err_o),
    .bus          (bus.master)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // BRAM model: read data (addr ^ 5) is valid for exactly one cycle, LAT cycles after REN
  logic [DATA_W-1:0] bram_pipe [LAT];
  always @(posedge clk) begin
    bram_pipe[0] <= (bus.PL_ENA_o && bus.PL_REN_o) ? {4'h0, bus.PL_ADDR_o ^ 32'h5} : 36'hBADBADBAD;
    for (int k = 1; k < LAT; k++) bram_pipe[k] <= bram_pipe[k-1];
  end
  assign bus.PL_DATA_i = bram_pipe[LAT-1];

  typedef struct {
    logic              ren;
    logic [1:0]        wen;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    int                cyc;
  } acc_t;

  acc_t obs[$];
  acc_t exp_q[$];
  logic [DATA_W-1:0] rd_exp[$];

  // PL port recorder
  always @(negedge clk) begin
    if (bus.PL_ENA_o)
      obs.push_back('{bus.PL_REN_o, bus.PL_WEN_o, bus.PL_ADDR_o, bus.PL_DATA_o, cyc});
    else if (bus.PL_REN_o || bus.PL_WEN_o != 2'b00)
      stray++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // runs one write session; queues one expected access per accepted handshake
  task automatic drive_write(input logic [ADDR_W-1:0] base, input int count, input bit toggle,
                             input int abort_idx, output int hs_last, output int abort_cyc,
                             output int done_cyc);
    int i, g;
    bit aborted;
    logic [ADDR_W-1:0] a;
    acc_t e;
    i = 0; g = 0; aborted = 0; a = base;
    hs_last = -1; abort_cyc = -1; done_cyc = -1;
    start_i = 1'b1; mode_i = 1'b0; base_addr_i = base; word_count_i = 16'(count);
    tick();
    start_i = 1'b0;
    while (done_cyc < 0 && g < 200) begin
      bus.wdata_valid_i = toggle ? g[0] : 1'b1;
      bus.wdata_i       = 36'h9_0000_00A0 + 36'(i);
      abort_i           = !aborted && (i == abort_idx) && bus.wdata_ready_o;
      @(negedge clk);
      if (done_o) done_cyc = cyc;
      if (abort_i) begin
        aborted = 1; abort_cyc = cyc;
      end else if (bus.wdata_ready_o && bus.wdata_valid_i) begin
        e = '{1'b0, 2'b11, a, bus.wdata_i, cyc + 1};
        exp_q.push_back(e);
        hs_last = cyc; a = a + 32'd1; i++;
      end
      tick();
      g++;
    end
    bus.wdata_valid_i = 1'b0;
    abort_i = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    n_cmp++;
    if ({busy_o, done_o, err_o, bus.wdata_ready_o, bus.rdata_valid_o, bus.PL_INIT_o,
         bus.PL_ENA_o, bus.PL_REN_o, bus.PL_WEN_o} !== '0) begin
      n_bad++; $display("FAIL reset_ctrl: got %b want 0", {busy_o, done_o, err_o, bus.wdata_ready_o,
                        bus.rdata_valid_o, bus.PL_INIT_o, bus.PL_ENA_o, bus.PL_REN_o, bus.PL_WEN_o});
    end
    n_cmp++;
    if ({bus.rdata_o, bus.PL_ADDR_o, bus.PL_DATA_o} !== '0) begin
      n_bad++; $display("FAIL reset_data: got %h want 0", {bus.rdata_o, bus.PL_ADDR_o, bus.PL_DATA_o});
    end
    tick();
    rst_n = 1'b1;
    tick();
    n_cmp++;
    if (busy_o !== 1'b0) begin n_bad++; $display("FAIL reset_idle: busy=%b want 0", busy_o); end
  endtask

  task automatic test_write_burst();
    int hs_last, ab, dn;
    acc_t o, e;
    obs.delete(); exp_q.delete();
    drive_write(32'h100, 4, 1'b0, -1, hs_last, ab, dn);
    tick();
    n_cmp++;
    if (exp_q.size() != 4 || obs.size() != 4) begin
      n_bad++; $display("FAIL burst_count: got obs=%0d exp=%0d want 4", obs.size(), exp_q.size());
    end
    while (obs.size() > 0 && exp_q.size() > 0) begin
      o = obs.pop_front(); e = exp_q.pop_front();
      n_cmp++;
      if ({o.ren, o.wen, o.addr, o.data} !== {e.ren, e.wen, e.addr, e.data} || o.cyc != e.cyc) begin
        n_bad++; $display("FAIL burst_access: got ren=%b wen=%b addr=%h data=%h cyc=%0d want ren=%b wen=%b addr=%h data=%h cyc=%0d",
                          o.ren, o.wen, o.addr, o.data, o.cyc, e.ren, e.wen, e.addr, e.data, e.cyc);
      end
    end
    n_cmp++;
    if (dn < 0 || dn != hs_last + 1) begin
      n_bad++; $display("FAIL burst_done: got done cycle %0d want %0d", dn, hs_last + 1);
    end
    n_cmp++;
    if (err_o !== 1'b0 || busy_o !== 1'b0) begin
      n_bad++; $display("FAIL burst_status: got err=%b busy=%b want 0 0", err_o, busy_o);
    end
  endtask

  task automatic test_write_toggle();
    int hs_last, ab, dn;
    acc_t o, e;
    obs.delete(); exp_q.delete();
    drive_write(32'h2000, 3, 1'b1, -1, hs_last, ab, dn);
    tick();
    n_cmp++;
    if (exp_q.size() != 3 || obs.size() != 3) begin
      n_bad++; $display("FAIL toggle_count: got obs=%0d exp=%0d want 3", obs.size(), exp_q.size());
    end
    while (obs.size() > 0 && exp_q.size() > 0) begin
      o = obs.pop_front(); e = exp_q.pop_front();
      n_cmp++;
      if ({o.ren, o.wen, o.addr, o.data} !== {e.ren, e.wen, e.addr, e.data} || o.cyc != e.cyc) begin
        n_bad++; $display("FAIL toggle_access: got addr=%h data=%h cyc=%0d want addr=%h data=%h cyc=%0d",
                          o.addr, o.data, o.cyc, e.addr, e.data, e.cyc);
      end
    end
    n_cmp++;
    if (dn != hs_last + 1) begin n_bad++; $display("FAIL toggle_done: got %0d want %0d", dn, hs_last + 1); end
  endtask

  task automatic test_readback();
    int w, held, g, n_at_hold;
    bit done_seen;
    logic [DATA_W-1:0] hold_val, ev;
    logic [ADDR_W-1:0] a;
    acc_t o, e;
    obs.delete(); exp_q.delete(); rd_exp.delete();
    for (int k = 0; k < 3; k++) begin
      a = 32'hFFFF_FFFE + 32'(k);
      e = '{1'b1, 2'b00, a, '0, 0};
      exp_q.push_back(e);
      rd_exp.push_back({4'h0, a ^ 32'h5});
    end
    w = 0; held = 0; g = 0; done_seen = 0; n_at_hold = 0; hold_val = '0;
    start_i = 1'b1; mode_i = 1'b1; base_addr_i = 32'hFFFF_FFFE; word_count_i = 16'd3;
    tick();
    start_i = 1'b0;
    while (!done_seen && g < 300) begin
      if (bus.rdata_valid_o && w == 1 && held < 5) begin
        bus.rdata_ready_i = 1'b0;
        if (held == 0) begin hold_val = bus.rdata_o; n_at_hold = obs.size(); end
        held++;
      end else begin
        bus.rdata_ready_i = 1'b1;
      end
      @(negedge clk);
      if (done_o) done_seen = 1;
      if (!bus.rdata_ready_i) begin
        n_cmp++;
        if (bus.rdata_valid_o !== 1'b1 || bus.rdata_o !== hold_val) begin
          n_bad++; $display("FAIL rd_hold_stable: got valid=%b data=%h want 1 %h", bus.rdata_valid_o, bus.rdata_o, hold_val);
        end
      end
      if (bus.rdata_valid_o && bus.rdata_ready_i) begin
        ev = (rd_exp.size() > 0) ? rd_exp.pop_front() : 36'hFFFFFFFFF;
        n_cmp++;
        if (bus.rdata_o !== ev) begin n_bad++; $display("FAIL rd_data: got %h want %h", bus.rdata_o, ev); end
        if (w == 1) begin
          n_cmp++;
          if (obs.size() != n_at_hold) begin
            n_bad++; $display("FAIL rd_hold_noissue: got %0d accesses want %0d", obs.size(), n_at_hold);
          end
        end
        w++;
      end
      tick();
      g++;
    end
    bus.rdata_ready_i = 1'b0;
    n_cmp++;
    if (!done_seen || w != 3 || held != 5) begin
      n_bad++; $display("FAIL rd_session: got done=%0d words=%0d held=%0d want 1 3 5", done_seen, w, held);
    end
    n_cmp++;
    if (obs.size() != 3) begin n_bad++; $display("FAIL rd_count: got %0d want 3", obs.size()); end
    while (obs.size() > 0 && exp_q.size() > 0) begin
      o = obs.pop_front(); e = exp_q.pop_front();
      n_cmp++;
      if ({o.ren, o.wen, o.addr} !== {e.ren, e.wen, e.addr}) begin
        n_bad++; $display("FAIL rd_issue: got ren=%b wen=%b addr=%h want ren=%b wen=%b addr=%h",
                          o.ren, o.wen, o.addr, e.ren, e.wen, e.addr);
      end
    end
  endtask

  task automatic test_abort();
    int hs_last, ab, dn;
    acc_t o, e;
    obs.delete(); exp_q.delete();
    drive_write(32'h4000, 8, 1'b0, 1, hs_last, ab, dn);
    tick(); tick();
    n_cmp++;
    if (obs.size() != 1 || exp_q.size() != 1) begin
      n_bad++; $display("FAIL abort_count: got obs=%0d exp=%0d want 1", obs.size(), exp_q.size());
    end
    while (obs.size() > 0 && exp_q.size() > 0) begin
      o = obs.pop_front(); e = exp_q.pop_front();
      n_cmp++;
      if ({o.wen, o.addr, o.data} !== {e.wen, e.addr, e.data} || o.cyc != e.cyc) begin
        n_bad++; $display("FAIL abort_access: got addr=%h data=%h want addr=%h data=%h", o.addr, o.data, e.addr, e.data);
      end
    end
    n_cmp++;
    if (ab < 0 || dn != ab + 1) begin n_bad++; $display("FAIL abort_done: got %0d want %0d", dn, ab + 1); end
    n_cmp++;
    if (err_o !== 1'b1) begin n_bad++; $display("FAIL abort_err: got %b want 1", err_o); end
  endtask

  task automatic test_count0();
    obs.delete();
    start_i = 1'b1; mode_i = 1'b1; base_addr_i = 32'h55; word_count_i = '0;
    tick();
    start_i = 1'b0;
    n_cmp++;
    if ({busy_o, bus.PL_INIT_o, done_o, err_o} !== 4'b1100) begin
      n_bad++; $display("FAIL cnt0_c1: got busy/init/done/err=%b want 1100", {busy_o, bus.PL_INIT_o, done_o, err_o});
    end
    tick();
    n_cmp++;
    if ({busy_o, bus.PL_INIT_o, done_o} !== 3'b111) begin
      n_bad++; $display("FAIL cnt0_c2: got busy/init/done=%b want 111", {busy_o, bus.PL_INIT_o, done_o});
    end
    tick();
    n_cmp++;
    if ({busy_o, bus.PL_INIT_o, done_o} !== 3'b000) begin
      n_bad++; $display("FAIL cnt0_c3: got busy/init/done=%b want 000", {busy_o, bus.PL_INIT_o, done_o});
    end
    n_cmp++;
    if (obs.size() != 0) begin n_bad++; $display("FAIL cnt0_noaccess: got %0d accesses want 0", obs.size()); end
  endtask

  task automatic test_reset_mid();
    int hs_last, ab, dn;
    acc_t o, e;
    start_i = 1'b1; mode_i = 1'b1; base_addr_i = 32'h40; word_count_i = 16'd2;
    tick();
    start_i = 1'b0;
    tick();
    n_cmp++;
    if ({bus.PL_ENA_o, bus.PL_REN_o} !== 2'b11) begin
      n_bad++; $display("FAIL rstmid_issue: got ena/ren=%b want 11", {bus.PL_ENA_o, bus.PL_REN_o});
    end
    tick();
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({busy_o, done_o, err_o, bus.wdata_ready_o, bus.rdata_valid_o, bus.rdata_o, bus.PL_INIT_o,
         bus.PL_ENA_o, bus.PL_REN_o, bus.PL_WEN_o, bus.PL_ADDR_o, bus.PL_DATA_o} !== '0) begin
      n_bad++; $display("FAIL rstmid_outputs: got busy=%b init=%b addr=%h data=%h rdata=%h want all 0",
                        busy_o, bus.PL_INIT_o, bus.PL_ADDR_o, bus.PL_DATA_o, bus.rdata_o);
    end
    tick();
    rst_n = 1'b1;
    tick();
    n_cmp++;
    if (busy_o !== 1'b0) begin n_bad++; $display("FAIL rstmid_idle: busy=%b want 0", busy_o); end
    obs.delete(); exp_q.delete();
    drive_write(32'h300, 2, 1'b0, -1, hs_last, ab, dn);
    tick();
    n_cmp++;
    if (obs.size() != 2 || exp_q.size() != 2) begin
      n_bad++; $display("FAIL rstmid_count: got obs=%0d exp=%0d want 2", obs.size(), exp_q.size());
    end
    while (obs.size() > 0 && exp_q.size() > 0) begin
      o = obs.pop_front(); e = exp_q.pop_front();
      n_cmp++;
      if ({o.wen, o.addr, o.data} !== {e.wen, e.addr, e.data} || o.cyc != e.cyc) begin
        n_bad++; $display("FAIL rstmid_access: got addr=%h data=%h want addr=%h data=%h", o.addr, o.data, e.addr, e.data);
      end
    end
    n_cmp++;
    if (dn != hs_last + 1 || err_o !== 1'b0) begin
      n_bad++; $display("FAIL rstmid_done: got done=%0d err=%b want %0d 0", dn, err_o, hs_last + 1);
    end
  endtask

  task automatic test_no_stray();
    n_cmp++;
    if (stray != 0) begin n_bad++; $display("FAIL stray_strobes: got %0d want 0", stray); end
  endtask

  initial begin
    bus.wdata_valid_i = 1'b0;
    bus.wdata_i       = '0;
    bus.rdata_ready_i = 1'b0;
    test_reset();
    test_write_burst();
    test_write_toggle();
    test_readback();
    test_abort();
    test_count0();
    test_reset_mid();
    test_no_stray();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
